// File: rtl/counter_w_decoder.sv
// Receive-side monitor for the 4-bit up-by-two/down-by-one w-counter stream.
// Classifies each sampled transition, recovers w, tracks lock and counts errors.
module counter_w_decoder #(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  input  logic             in_rst,
  output logic             w_out,
  output logic             w_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  // Interface: a sample is consumed on every cycle in_valid is high; there is
  // no backpressure, so the monitor must keep up with the bus at full rate.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_CNT_4 = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       run_q, run_d;
  logic             w_out_q, w_out_d;
  logic             w_valid_q, w_valid_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [3:0] up_next;
  logic [3:0] dn_next;
  logic       up_ok;
  logic       dn_ok;
  logic [3:0] run_inc;

  // 8 and 15 both wrap straight to 0 on an UP step instead of p+2.
  assign up_next = ((prev_q == 4'd8) || (prev_q == 4'd15)) ? 4'd0 : prev_q + 4'd2;
  assign dn_next = prev_q - 4'd1;
  assign up_ok   = (in_data == up_next);
  assign dn_ok   = (in_data == dn_next);
  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    w_out_d     = w_out_q;
    w_valid_d   = 1'b0;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (in_valid) begin
      prev_d = in_data;
      case (state_q)
        IDLE: begin
          if (!in_rst || (in_data == 4'd0)) begin
            state_d = ACQ;
            run_d   = 4'd0;
          end
        end
        ACQ, LOCKED: begin
          if (in_rst) begin
            // Generator reset: a zero sample re-anchors, anything else is lost sync.
            locked_d = 1'b0;
            run_d    = 4'd0;
            if (in_data == 4'd0) begin
              state_d = ACQ;
            end else begin
              err_pulse_d = (state_q == LOCKED);
              state_d     = IDLE;
            end
          end else if (up_ok || dn_ok) begin
            w_out_d   = up_ok;
            w_valid_d = 1'b1;
            if (state_q == ACQ) begin
              run_d = run_inc;
              if (run_inc == LOCK_CNT_4) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end
          end else begin
            run_d = 4'd0;
            if (state_q == LOCKED) begin
              err_pulse_d = 1'b1;
              locked_d    = 1'b0;
              state_d     = ACQ;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
          run_d    = 4'd0;
        end
      endcase
    end

    if (err_pulse_d && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_q      <= 4'd0;
      run_q       <= 4'd0;
      w_out_q     <= 1'b0;
      w_valid_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      w_out_q     <= w_out_d;
      w_valid_q   <= w_valid_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign w_out     = w_out_q;
  assign w_valid   = w_valid_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_counter_w_decoder.sv
// Directed bench for counter_w_decoder: instance a uses defaults (LOCK_CNT=3,
// ERR_W=8); instance b uses LOCK_CNT=1, ERR_W=2 for lock and saturation edges.
module tb_counter_w_decoder;

  logic       clk;
  logic       reset;

  logic       a_valid, a_rst;
  logic [3:0] a_data;
  logic       a_w_out, a_w_valid, a_locked, a_err_pulse;
  logic [7:0] a_err_count;
  logic [1:0] a_state;

  logic       b_valid, b_rst;
  logic [3:0] b_data;
  logic       b_w_out, b_w_valid, b_locked, b_err_pulse;
  logic [1:0] b_err_count;
  logic [1:0] b_state;

  int n_checks = 0;
  int n_errors = 0;

  logic exp_q[$];

  counter_w_decoder u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (a_valid),
    .in_data   (a_data),
    .in_rst    (a_rst),
    .w_out     (a_w_out),
    .w_valid   (a_w_valid),
    .locked    (a_locked),
    .err_pulse (a_err_pulse),
    .err_count (a_err_count),
    .state     (a_state)
  );

  counter_w_decoder #(.LOCK_CNT(1), .ERR_W(2)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (b_valid),
    .in_data   (b_data),
    .in_rst    (b_rst),
    .w_out     (b_w_out),
    .w_valid   (b_w_valid),
    .locked    (b_locked),
    .err_pulse (b_err_pulse),
    .err_count (b_err_count),
    .state     (b_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every w_valid pulse on instance a must match the next queued w.
  always @(negedge clk) begin
    if (a_w_valid === 1'b1) begin
      if (exp_q.size() == 0) check("w_pulse_unexpected", 32'd1, 32'd0);
      else check("w_pulse_value", {31'd0, a_w_out}, {31'd0, exp_q.pop_front()});
    end
  end

  task automatic apply_reset();
    reset   = 1'b1;
    a_valid = 1'b0; a_rst = 1'b0; a_data = 4'd0;
    b_valid = 1'b0; b_rst = 1'b0; b_data = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_a_w_out"},     {31'd0, a_w_out},     32'd0);
    check({tag, "_a_w_valid"},   {31'd0, a_w_valid},   32'd0);
    check({tag, "_a_locked"},    {31'd0, a_locked},    32'd0);
    check({tag, "_a_err_pulse"}, {31'd0, a_err_pulse}, 32'd0);
    check({tag, "_a_err_count"}, {24'd0, a_err_count}, 32'd0);
    check({tag, "_a_state"},     {30'd0, a_state},     32'd0);
  endtask

  // Driver for instance a with the hand-computed expected outputs one cycle later.
  task automatic step_a(input string tag, input logic v, input logic r, input logic [3:0] d,
                        input logic ewv, input logic ew, input logic [1:0] est,
                        input logic [7:0] eec, input logic eep);
    a_valid = v; a_rst = r; a_data = d;
    if (ewv) exp_q.push_back(ew);
    @(posedge clk);
    #1;
    check({tag, "_w_valid"},   {31'd0, a_w_valid},   {31'd0, ewv});
    check({tag, "_w_out"},     {31'd0, a_w_out},     {31'd0, ew});
    check({tag, "_state"},     {30'd0, a_state},     {30'd0, est});
    check({tag, "_locked"},    {31'd0, a_locked},    {31'd0, (est == 2'd2)});
    check({tag, "_err_pulse"}, {31'd0, a_err_pulse}, {31'd0, eep});
    check({tag, "_err_count"}, {24'd0, a_err_count}, {24'd0, eec});
    a_valid = 1'b0; a_rst = 1'b0;
  endtask

  task automatic step_b(input string tag, input logic [3:0] d, input logic [1:0] est,
                        input logic [1:0] eec, input logic eep);
    b_valid = 1'b1; b_rst = 1'b0; b_data = d;
    @(posedge clk);
    #1;
    check({tag, "_state"},     {30'd0, b_state},     {30'd0, est});
    check({tag, "_locked"},    {31'd0, b_locked},    {31'd0, (est == 2'd2)});
    check({tag, "_err_pulse"}, {31'd0, b_err_pulse}, {31'd0, eep});
    check({tag, "_err_count"}, {30'd0, b_err_count}, {30'd0, eec});
    b_valid = 1'b0;
  endtask

  logic [3:0] b_seq [11] = '{4'd0, 4'd2, 4'd5, 4'd7, 4'd0, 4'd15, 4'd3, 4'd5, 4'd0, 4'd15, 4'd9};
  logic [1:0] b_st  [11] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
  logic [1:0] b_ec  [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
  logic       b_ep  [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    apply_reset();
    check_a_zero("reset");

    // Lock on UP stream, including 8->0
    step_a("up0", 1, 0, 4'd0, 0, 0, 2'd1, 8'd0, 0);
    step_a("up2", 1, 0, 4'd2, 1, 1, 2'd1, 8'd0, 0);
    step_a("up4", 1, 0, 4'd4, 1, 1, 2'd1, 8'd0, 0);
    step_a("up6", 1, 0, 4'd6, 1, 1, 2'd2, 8'd0, 0);
    step_a("up8", 1, 0, 4'd8, 1, 1, 2'd2, 8'd0, 0);
    step_a("up8to0", 1, 0, 4'd0, 1, 1, 2'd2, 8'd0, 0);

    apply_reset();
    check_a_zero("reset2");

    // DOWN with wrap 0->15
    step_a("dn2",  1, 0, 4'd2,  0, 0, 2'd1, 8'd0, 0);
    step_a("dn1",  1, 0, 4'd1,  1, 0, 2'd1, 8'd0, 0);
    step_a("dn0",  1, 0, 4'd0,  1, 0, 2'd1, 8'd0, 0);
    step_a("dn15", 1, 0, 4'd15, 1, 0, 2'd2, 8'd0, 0);
    step_a("dn14", 1, 0, 4'd14, 1, 0, 2'd2, 8'd0, 0);

    // Special UP wraps while LOCKED: 14->0, 13->15, 15->0, and odd run 7,9,11
    step_a("w14to0",  1, 0, 4'd0,  1, 1, 2'd2, 8'd0, 0);
    step_a("w0to15",  1, 0, 4'd15, 1, 0, 2'd2, 8'd0, 0);
    step_a("w15to14", 1, 0, 4'd14, 1, 0, 2'd2, 8'd0, 0);
    step_a("w14to13", 1, 0, 4'd13, 1, 0, 2'd2, 8'd0, 0);
    step_a("w13to15", 1, 0, 4'd15, 1, 1, 2'd2, 8'd0, 0);
    step_a("w15to0",  1, 0, 4'd0,  1, 1, 2'd2, 8'd0, 0);
    for (int i = 2; i <= 8; i += 2)
      step_a("w_even", 1, 0, 4'(i), 1, 1, 2'd2, 8'd0, 0);
    step_a("w8to7",   1, 0, 4'd7,  1, 0, 2'd2, 8'd0, 0);
    step_a("w7to9",   1, 0, 4'd9,  1, 1, 2'd2, 8'd0, 0);
    step_a("w9to11",  1, 0, 4'd11, 1, 1, 2'd2, 8'd0, 0);

    // Error while LOCKED, then relock
    step_a("e13", 1, 0, 4'd13, 1, 1, 2'd2, 8'd0, 0);
    step_a("e15", 1, 0, 4'd15, 1, 1, 2'd2, 8'd0, 0);
    for (int i = 0; i <= 6; i += 2)
      step_a("e_run", 1, 0, 4'(i), 1, 1, 2'd2, 8'd0, 0);
    step_a("e_bad9", 1, 0, 4'd9,  0, 1, 2'd1, 8'd1, 1);
    step_a("e11",    1, 0, 4'd11, 1, 1, 2'd1, 8'd1, 0);
    step_a("e13b",   1, 0, 4'd13, 1, 1, 2'd1, 8'd1, 0);
    step_a("e15b",   1, 0, 4'd15, 1, 1, 2'd2, 8'd1, 0);

    // Gap: invalid samples carry junk data and must change nothing
    for (int i = 0; i < 5; i++)
      step_a("gap", 0, 1, 4'd9, 0, 1, 2'd2, 8'd1, 0);
    step_a("gap_resume", 1, 0, 4'd0, 1, 1, 2'd2, 8'd1, 0);

    // in_rst handling
    step_a("rst0_locked", 1, 1, 4'd0, 0, 1, 2'd1, 8'd1, 0);
    step_a("rl2",  1, 0, 4'd2, 1, 1, 2'd1, 8'd1, 0);
    step_a("rl4",  1, 0, 4'd4, 1, 1, 2'd1, 8'd1, 0);
    step_a("rl6",  1, 0, 4'd6, 1, 1, 2'd2, 8'd1, 0);
    step_a("rst5_locked", 1, 1, 4'd5, 0, 1, 2'd0, 8'd2, 1);
    step_a("rst3_idle",   1, 1, 4'd3, 0, 1, 2'd0, 8'd2, 0);
    step_a("idle4",       1, 0, 4'd4, 0, 1, 2'd1, 8'd2, 0);
    step_a("acq_bad9",    1, 0, 4'd9, 0, 1, 2'd1, 8'd2, 0);
    step_a("rst7_acq",    1, 1, 4'd7, 0, 1, 2'd0, 8'd2, 0);
    step_a("pre0",        1, 0, 4'd0, 0, 1, 2'd1, 8'd2, 0);
    step_a("pre2",        1, 0, 4'd2, 1, 1, 2'd1, 8'd2, 0);

    // Reset mid-stream dominates a valid sample
    reset = 1'b1; a_valid = 1'b1; a_data = 4'd4;
    @(posedge clk);
    #1;
    check_a_zero("midreset");
    reset = 1'b0; a_valid = 1'b0;

    // LOCK_CNT=1 locks on first legal step; ERR_W=2 saturates at 3
    for (int i = 0; i < 11; i++)
      step_b($sformatf("sat%0d", i), b_seq[i], b_st[i], b_ec[i], b_ep[i]);

    reset = 1'b1; b_valid = 1'b1; b_data = 4'd11;
    @(posedge clk);
    #1;
    check("midreset_b_state",     {30'd0, b_state},     32'd0);
    check("midreset_b_err_count", {30'd0, b_err_count}, 32'd0);
    check("midreset_b_locked",    {31'd0, b_locked},    32'd0);
    check("midreset_b_w_out",     {31'd0, b_w_out},     32'd0);
    check("midreset_b_w_valid",   {31'd0, b_w_valid},   32'd0);
    check("midreset_b_err_pulse", {31'd0, b_err_pulse}, 32'd0);
    reset = 1'b0; b_valid = 1'b0;

    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_w_decoder.md
Name: counter_w_decoder

Overview:
- Receive-side monitor for the 4-bit up-by-two/down-by-one w-counter stream.
- Samples the counter value each valid cycle and classifies every transition as UP (w=1), DOWN (w=0) or ILLEGAL.
- Recovers the direction bit w and tracks lock status. Counts protocol errors.
- Sits on the consumer side of the counter bus and drives the recovered w and health flags to downstream logic.

Parameters:
- LOCK_CNT, 3, consecutive legal transitions required to enter LOCKED (legal range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_data carries a new counter sample this cycle.
- in_data  in  4  sampled counter value.
- in_rst  in  1  generator was reset for this sample; qualified by in_valid.
- w_out  out  1  recovered direction of last legal transition (1=UP, 0=DOWN).
- w_valid  out  1  one-cycle pulse: w_out updated by a legal transition.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse on an error while LOCKED.
- err_count  out  ERR_W  saturating count of err_pulse events.
- state  out  2  FSM state: IDLE=0, ACQ=1, LOCKED=2.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock clk.
- Reset values: w_out=0, w_valid=0, locked=0, err_pulse=0, err_count=0, state=IDLE, prev=0, run=0.
- Latency: all outputs are registered and reflect sample N on the cycle after in_valid.
- When in_valid=0, all state holds and w_valid and err_pulse are 0.
- Legal UP from prev p:
  - p=8 or p=15 gives next=0.
  - Otherwise next=(p+2) mod 16, so 14→0 and 13→15.
- Legal DOWN from prev p:
  - p=0 gives next=15.
  - Otherwise next=p-1.
- UP and DOWN next values never coincide, so classification is unambiguous. Any other next value is ILLEGAL.
- IDLE: on in_valid, store prev=in_data and go to ACQ with run=0. No w_valid. in_rst is ignored except that it requires in_data=0; a nonzero value keeps the FSM in IDLE.
- ACQ, legal transition:
  - w_out=dir, w_valid=1, run=run+1.
  - If run+1==LOCK_CNT, go to LOCKED and set locked=1.
- ACQ, illegal transition: run=0, stay in ACQ. No err_pulse and no count.
- LOCKED, legal transition: w_out=dir, w_valid=1.
- LOCKED, illegal transition:
  - err_pulse=1 and err_count increments, saturating at all-ones.
  - locked=0, go to ACQ with run=0.
- prev is updated to in_data on every valid sample in every state.
- in_rst=1 with in_valid, in ACQ or LOCKED:
  - in_data=0: prev=0, go to ACQ with run=0, locked=0. No w_valid, no error (a legal re-anchor).
  - in_data≠0: counts as an error only if the FSM was LOCKED (err_pulse and count), then go to IDLE.
- in_rst takes priority over transition classification.
- Simultaneous events: on a LOCKED illegal transition, err_pulse and locked fall in the same cycle. w_valid and err_pulse are never high together.
- Reset mid-operation dominates everything: FSM returns to IDLE and err_count clears.
- run counter is 4 bits; LOCK_CNT=1 means the first legal transition locks.

Test Plan:
- Lock on UP stream: valid samples 0,2,4,6,8,0 (LOCK_CNT=3) → w_valid pulses on the 2nd..6th samples with w_out=1. locked rises one cycle after sample "6". err_count=0.
- DOWN with wrap: 2,1,0,15,14 → w_out=0 on every pulse. locked after sample "15". No errors.
- UP special wraps while LOCKED: ...,13,15,0 then 7,9,11 → all UP legal with w_out=1. 8→0 and 14→0 also legal. err_pulse never asserts.
- Error while LOCKED: locked stream 4,6 then 9 → err_pulse=1 for one cycle, err_count=1, locked=0, state=ACQ. Then 11,13,15 relocks and err_count stays 1.
- in_rst and gaps:
  - in_valid low for 5 cycles mid-stream → outputs hold, no pulses.
  - in_rst=1 with data 0 while LOCKED → state=ACQ, no err.
  - in_rst=1 with data 5 while LOCKED → err_count+1, state=IDLE.
- Saturation and reset: ERR_W=2, force 5 LOCKED errors → err_count sticks at 3. Assert reset mid-stream → all outputs 0, state=IDLE the next cycle.
